// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between instruction fetch (IF) and load/store (LS)
// Ports: clk/reset (sync, active-high); if_req/if_addr in, if_gnt/if_rvalid/if_rdata out;
//   ls_req/ls_we/ls_addr/ls_wdata/ls_dmtype in, ls_gnt/ls_rvalid/ls_rdata out;
//   mem_req/mem_we/mem_addr/mem_wdata/mem_dmtype out, mem_ack/mem_rdata in; busy out.
// LS has priority; after STARVE_MAX consecutive LS grants with IF waiting, IF is forced.
// Optional DMARB_TIMEOUT_EN: adds sticky err output and aborts BUSY after TIMEOUT cycles without mem_ack.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int STARVE_MAX = 4
`ifdef DMARB_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  input  logic [2:0]    ls_dmtype,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_dmtype,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
`ifdef DMARB_TIMEOUT_EN
  , output logic        err
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;
  state_t state, state_n;
  logic [3:0] starve_cnt, starve_n;
  logic pick_ls, pick_if, done, expire;
  logic [DW-1:0] rd_n;
`ifdef DMARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  assign expire = state != IDLE && !mem_ack && tmo_cnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
      err <= 1'b0;
    end else begin
      tmo_cnt <= (pick_ls || pick_if) ? '0 : (state != IDLE) ? tmo_cnt + 1'b1 : tmo_cnt;
      if (expire) err <= 1'b1;
    end
  end
`else
  assign expire = 1'b0;
`endif
  always_comb begin
    pick_ls = state == IDLE && ls_req && !(if_req && starve_cnt == 4'(STARVE_MAX));
    pick_if = state == IDLE && if_req && !pick_ls;
    done = state != IDLE && (mem_ack || expire);
    // stores and timeout aborts return zero data
    rd_n = (mem_we || !mem_ack) ? '0 : mem_rdata;
    state_n = pick_ls ? BUSY_LS : pick_if ? BUSY_IF : done ? IDLE : state;
    starve_n = (pick_if || (state == IDLE && !if_req)) ? 4'd0 :
               (pick_ls && starve_cnt != 4'(STARVE_MAX)) ? starve_cnt + 4'd1 : starve_cnt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      starve_cnt <= '0;
    end else begin
      state <= state_n;
      starve_cnt <= starve_n;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      if_gnt <= 1'b0;
      ls_gnt <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if_rdata <= '0;
      ls_rdata <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_dmtype <= '0;
    end else begin
      if_gnt <= pick_if;
      ls_gnt <= pick_ls;
      if_rvalid <= done && state == BUSY_IF;
      ls_rvalid <= done && state == BUSY_LS;
      if (done && state == BUSY_IF) if_rdata <= rd_n;
      if (done && state == BUSY_LS) ls_rdata <= rd_n;
      if (pick_ls) begin
        mem_we <= ls_we;
        mem_addr <= ls_addr;
        mem_wdata <= ls_wdata;
        mem_dmtype <= ls_dmtype;
      end else if (pick_if) begin
        mem_we <= 1'b0;
        mem_addr <= if_addr;
        mem_wdata <= '0;
        mem_dmtype <= 3'b100;
      end
    end
  end
  assign busy = state != IDLE;
  assign mem_req = busy;
endmodule
